// File: rtl/imm_decode_ctrl.sv
// RVX10 D->E immediate controller: opcode decode, immext capture, 2-entry skid into ID/EX.
// Optional build macro RVX10_UTYPE_EN enables lui/auipc as class U with a locally built immediate.
module imm_decode_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter logic [6:0]  CUSTOM_OPC = 7'b0001011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            valid_d,
  output logic            ready_d,
  output logic [1:0]      immsrc,
  input  logic [31:0]     immext_d,
  input  logic            flush,
  output logic            valid_e,
  input  logic            ready_e,
  output logic [31:0]     instr_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] immext_e,
  output logic [2:0]      immcls_e,
  output logic            illegal_e
);

  localparam logic [2:0] ClsNone = 3'd0;
  localparam logic [2:0] ClsI    = 3'd1;
  localparam logic [2:0] ClsS    = 3'd2;
  localparam logic [2:0] ClsB    = 3'd3;
  localparam logic [2:0] ClsJ    = 3'd4;
`ifdef RVX10_UTYPE_EN
  localparam logic [2:0] ClsU    = 3'd5;
`endif

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      cls;
    logic            ill;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  dec_cls;
  logic        dec_ill;
  logic [31:0] dec_imm;
  entry_t      in_entry;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept;

  assign opcode = instr_d[6:0];

  always_comb begin
    immsrc  = 2'b00;
    dec_cls = ClsNone;
    dec_ill = 1'b0;
    dec_imm = 32'h0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_cls = ClsI;
        dec_imm = immext_d;
      end
      7'b0100011: begin
        immsrc  = 2'b01;
        dec_cls = ClsS;
        dec_imm = immext_d;
      end
      7'b1100011: begin
        immsrc  = 2'b10;
        dec_cls = ClsB;
        dec_imm = immext_d;
      end
      7'b1101111: begin
        immsrc  = 2'b11;
        dec_cls = ClsJ;
        dec_imm = immext_d;
      end
      7'b0110011, CUSTOM_OPC: begin
        dec_cls = ClsNone;
      end
      7'b0110111, 7'b0010111: begin
`ifdef RVX10_UTYPE_EN
        // Extend unit has no U format; build the upper immediate here.
        dec_cls = ClsU;
        dec_imm = {instr_d[31:12], 12'h000};
`else
        dec_ill = 1'b1;
`endif
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_entry = '{instr: instr_d, pc: pc_d, imm: XLEN'(dec_imm), cls: dec_cls, ill: dec_ill};

  // ready_d depends only on state, so there is no combinational path from ready_e.
  assign ready_d = ~skid_valid_q;
  assign accept  = valid_d & ready_d;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || ready_e) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign valid_e   = main_valid_q;
  assign instr_e   = main_q.instr;
  assign pc_e      = main_q.pc;
  assign immext_e  = main_q.imm;
  assign immcls_e  = main_q.cls;
  assign illegal_e = main_q.ill;

endmodule
